// File: rtl/rx_align_pkg.sv
// Shared types and constants for the RX training word aligner.
package rx_align_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WORD_W = 4;
    localparam int unsigned OFF_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        SLIP,
        LOCKED,
        FAIL
    } state_e;

    // Saturating increment for the 8-bit event counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rx_word_window_mux.sv
// Holds the previous valid word and selects a 4-bit window at the current bit offset.
module rx_word_window_mux
    import rx_align_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic [OFF_W-1:0]  offset_i,
    output logic [WORD_W-1:0] aligned_o
);

    logic [WORD_W-1:0]   prev_q;
    logic [2*WORD_W-1:0] win;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
        end else if (valid_i) begin
            prev_q <= data_i;
        end
    end

    // Older word sits in the low half, so bit 0 stays the earliest received bit.
    assign win       = {data_i, prev_q};
    assign aligned_o = win[offset_i +: WORD_W];

endmodule

// File: rtl/rx_train_word_align.sv
// Training-pattern word aligner: sweeps bit offsets until the pattern repeats, then tracks lock.
module rx_train_word_align
    import rx_align_pkg::*;
#(
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = 4'hC,
    parameter int unsigned       SETTLE_CYC    = 4,
    parameter int unsigned       MATCH_CNT     = 16,
    parameter int unsigned       ERR_THRESH    = 4,
    parameter int unsigned       MAX_SWEEPS    = 8
) (
    input  logic              SCLK,
    input  logic              RESET,
    input  logic              TRAIN_START,
    input  logic              IN_VALID,
    input  logic [WORD_W-1:0] IN_DATA,
    output logic [WORD_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    output logic [OFF_W-1:0]  SLIP_OFFSET,
    output logic              ALIGN_DONE,
    output logic              ALIGN_FAIL,
    output logic [CNT_W-1:0]  ERR_CNT
);

    logic [1:0]        rst_sync_q;
    logic              rst;
    state_e            state_q;
    logic [OFF_W-1:0]  offset_q;
    logic [CNT_W-1:0]  settle_cnt_q;
    logic [CNT_W-1:0]  match_cnt_q;
    logic [CNT_W-1:0]  sweep_cnt_q;
    logic [CNT_W-1:0]  consec_err_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [WORD_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              done_q;
    logic              fail_q;
    logic [WORD_W-1:0] aligned;
    logic              match;
    logic              pass_data;

    // Reset asserts immediately and releases two SCLK edges after RESET falls.
    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end
    assign rst = rst_sync_q[1];

    rx_word_window_mux u_win (
        .clk_i     (SCLK),
        .rst_i     (rst),
        .valid_i   (IN_VALID),
        .data_i    (IN_DATA),
        .offset_i  (offset_q),
        .aligned_o (aligned)
    );

    assign match     = (aligned == TRAIN_PATTERN);
    assign pass_data = IN_VALID && (state_q != IDLE) && (state_q != FAIL);

    always_ff @(posedge SCLK or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            offset_q     <= '0;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
            sweep_cnt_q  <= '0;
            consec_err_q <= '0;
            err_cnt_q    <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            out_valid_q <= pass_data;
            if (pass_data) begin
                out_data_q <= aligned;
            end

            if (TRAIN_START) begin
                state_q      <= SETTLE;
                offset_q     <= '0;
                settle_cnt_q <= '0;
                match_cnt_q  <= '0;
                sweep_cnt_q  <= '0;
                consec_err_q <= '0;
                err_cnt_q    <= '0;
                done_q       <= 1'b0;
                fail_q       <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    SETTLE: begin
                        if (IN_VALID) begin
                            if (settle_cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                                settle_cnt_q <= '0;
                                state_q      <= CHECK;
                            end else begin
                                settle_cnt_q <= settle_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    CHECK: begin
                        if (IN_VALID) begin
                            if (!match) begin
                                state_q <= SLIP;
                            end else if (match_cnt_q == CNT_W'(MATCH_CNT - 1)) begin
                                match_cnt_q <= '0;
                                done_q      <= 1'b1;
                                state_q     <= LOCKED;
                            end else begin
                                match_cnt_q <= match_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    SLIP: begin
                        offset_q     <= offset_q + OFF_W'(1);
                        match_cnt_q  <= '0;
                        settle_cnt_q <= '0;
                        if (offset_q == OFF_W'(3)) begin
                            sweep_cnt_q <= sweep_cnt_q + CNT_W'(1);
                            if (sweep_cnt_q == CNT_W'(MAX_SWEEPS - 1)) begin
                                fail_q  <= 1'b1;
                                state_q <= FAIL;
                            end else begin
                                state_q <= SETTLE;
                            end
                        end else begin
                            state_q <= SETTLE;
                        end
                    end
                    LOCKED: begin
                        if (IN_VALID) begin
                            if (match) begin
                                consec_err_q <= '0;
                            end else begin
                                err_cnt_q <= sat_inc(err_cnt_q);
                                if (consec_err_q == CNT_W'(ERR_THRESH - 1)) begin
                                    consec_err_q <= '0;
                                    sweep_cnt_q  <= '0;
                                    done_q       <= 1'b0;
                                    state_q      <= SLIP;
                                end else begin
                                    consec_err_q <= consec_err_q + CNT_W'(1);
                                end
                            end
                        end
                    end
                    FAIL: begin
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign OUT_DATA    = out_data_q;
    assign OUT_VALID   = out_valid_q;
    assign SLIP_OFFSET = offset_q;
    assign ALIGN_DONE  = done_q;
    assign ALIGN_FAIL  = fail_q;
    assign ERR_CNT     = err_cnt_q;

endmodule
